// File: rtl/ife_multi_dispatch.sv
// Block dispatcher: queues incoming instruction blocks and issues each either to a
// redundant set of idle cores (checked by commit) or to the serial path as fallback.
module ife_multi_dispatch #(
   parameter int BLOCK_ID_WIDTH = 8,
   parameter int INSTR_WIDTH    = 32,
   parameter int BLOCK_SIZE     = 4,
   parameter int NUM_CORES      = 4,
   parameter int MIN_CORES      = 2,
   parameter int QUEUE_DEPTH    = 4,
   parameter int STALL_LIMIT    = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [BLOCK_ID_WIDTH-1:0]         in_block_id,
   input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] in_block_data,
   input  logic                              in_is_safe,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [NUM_CORES-1:0]              core_busy,
   output logic [BLOCK_ID_WIDTH-1:0]         par_block_id,
   output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] par_block_data,
   output logic [NUM_CORES-1:0]              par_core_mask,
   output logic                              par_valid,
   input  logic                              commit_valid,
   input  logic [BLOCK_ID_WIDTH-1:0]         commit_block_id,
   input  logic                              commit_match,
   output logic [BLOCK_ID_WIDTH-1:0]         ser_block_id,
   output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] ser_block_data,
   output logic                              ser_valid,
   input  logic                              ser_ready,
   output logic                              ser_is_fallback,
   output logic                              commit_ok,
   output logic [15:0]                       fallback_count,
   output logic                              busy
);
   localparam int DW = BLOCK_SIZE * INSTR_WIDTH;
   localparam int EW = BLOCK_ID_WIDTH + DW + 1;
   localparam int QW = $clog2(QUEUE_DEPTH);
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [QW:0]   Q_FULL     = (QW + 1)'(QUEUE_DEPTH);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
   localparam logic [TW-1:0] TIME_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PAR_WAIT, SER_OUT} state_t;
   state_t state_reg, state_next;

   logic [EW-1:0]             q_mem [QUEUE_DEPTH];
   logic [QW-1:0]             wr_ptr_reg, rd_ptr_reg;
   logic [QW:0]               count_reg;
   logic [BLOCK_ID_WIDTH-1:0] head_id;
   logic [DW-1:0]             head_data;
   logic                      head_safe;
   logic                      push, pop, go_par, fall, commit_hit, cores_ok;
   logic [NUM_CORES-1:0]      sel_mask;
   logic [SW-1:0]             stall_reg, stall_next;
   logic [TW-1:0]             timer_reg, timer_next;

   assign in_ready = (count_reg != Q_FULL);
   assign push     = in_valid && in_ready;
   assign busy     = (state_reg != IDLE);
   assign {head_id, head_data, head_safe} = q_mem[rd_ptr_reg];
   assign cores_ok = ($countones(~core_busy) >= MIN_CORES);

   always_ff @(posedge clk) begin
      if (push) q_mem[wr_ptr_reg] <= {in_block_id, in_block_data, in_is_safe};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + QW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + QW'(1);
         if (push && !pop)      count_reg <= count_reg + (QW + 1)'(1);
         else if (pop && !push) count_reg <= count_reg - (QW + 1)'(1);
      end
   end

   // Pick the lowest-index MIN_CORES idle cores.
   always_comb begin
      int taken;
      sel_mask = '0;
      taken    = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!core_busy[i] && taken < MIN_CORES) begin
            sel_mask[i] = 1'b1;
            taken       = taken + 1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      go_par     = 1'b0;
      fall       = 1'b0;
      commit_hit = 1'b0;
      stall_next = stall_reg;
      timer_next = timer_reg;
      case (state_reg)
         IDLE: begin
            timer_next = '0;
            if (count_reg == '0) begin
               stall_next = '0;
            end else if (!head_safe || cores_ok || stall_reg == STALL_LAST) begin
               pop        = 1'b1;
               go_par     = head_safe && cores_ok;
               state_next = (head_safe && cores_ok) ? PAR_WAIT : SER_OUT;
               stall_next = '0;
            end else begin
               stall_next = stall_reg + SW'(1);
            end
         end
         PAR_WAIT: begin
            // A matching commit takes priority over an expiring timer.
            if (commit_valid && commit_block_id == par_block_id) begin
               commit_hit = commit_match;
               fall       = !commit_match;
               state_next = commit_match ? IDLE : SER_OUT;
            end else if (timer_reg == TIME_LAST) begin
               fall       = 1'b1;
               state_next = SER_OUT;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end
         SER_OUT: begin
            if (ser_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         stall_reg       <= '0;
         timer_reg       <= '0;
         par_valid       <= 1'b0;
         par_core_mask   <= '0;
         par_block_id    <= '0;
         par_block_data  <= '0;
         ser_valid       <= 1'b0;
         ser_block_id    <= '0;
         ser_block_data  <= '0;
         ser_is_fallback <= 1'b0;
         commit_ok       <= 1'b0;
         fallback_count  <= '0;
      end else begin
         state_reg     <= state_next;
         stall_reg     <= stall_next;
         timer_reg     <= timer_next;
         par_valid     <= go_par;
         par_core_mask <= go_par ? sel_mask : '0;
         commit_ok     <= commit_hit;
         if (go_par) begin
            par_block_id   <= head_id;
            par_block_data <= head_data;
         end
         if (pop && !go_par) begin
            ser_valid       <= 1'b1;
            ser_block_id    <= head_id;
            ser_block_data  <= head_data;
            ser_is_fallback <= 1'b0;
         end else if (fall) begin
            ser_valid       <= 1'b1;
            ser_block_id    <= par_block_id;
            ser_block_data  <= par_block_data;
            ser_is_fallback <= 1'b1;
         end else if (ser_valid && ser_ready) begin
            ser_valid <= 1'b0;
         end
         if (fall && fallback_count != 16'hFFFF) fallback_count <= fallback_count + 16'd1;
      end
   end
endmodule

// File: doc/ife_multi_dispatch.md
IFE_MULTI_DISPATCH -- requirements
Module: ife_multi_dispatch

Interface
REQ-001 SHALL have parameter BLOCK_ID_WIDTH, default 8, block tag width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 4, instructions per block.
REQ-004 SHALL have parameter NUM_CORES, default 4, number of parallel cores.
REQ-005 SHALL have parameter MIN_CORES, default 2, cores per redundant parallel dispatch (2..NUM_CORES).
REQ-006 SHALL have parameter QUEUE_DEPTH, default 4, block queue entries (power of 2).
REQ-007 SHALL have parameter STALL_LIMIT, default 16, cycles a safe head waits for cores before serial fallback.
REQ-008 SHALL have parameter TIMEOUT_CYCLES, default 64, cycles to wait for commit before fallback.
REQ-009 SHALL have ports: clk  in  1  clock; rst  in  1  reset. One clock; reset is asynchronous and active-high.
REQ-010 SHALL have ports: in_block_id  in  BLOCK_ID_WIDTH; in_block_data  in  BLOCK_SIZE*INSTR_WIDTH; in_is_safe  in  1  dependence-free flag; in_valid  in  1; in_ready  out  1.
REQ-011 SHALL have port: core_busy  in  NUM_CORES  per-core busy.
REQ-012 SHALL have ports: par_block_id  out  BLOCK_ID_WIDTH; par_block_data  out  BLOCK_SIZE*INSTR_WIDTH; par_core_mask  out  NUM_CORES; par_valid  out  1  one-cycle issue pulse.
REQ-013 SHALL have ports: commit_valid  in  1; commit_block_id  in  BLOCK_ID_WIDTH; commit_match  in  1  core results agree.
REQ-014 SHALL have ports: ser_block_id  out  BLOCK_ID_WIDTH; ser_block_data  out  BLOCK_SIZE*INSTR_WIDTH; ser_valid  out  1; ser_ready  in  1; ser_is_fallback  out  1.
REQ-015 SHALL have ports: commit_ok  out  1  one-cycle pulse; fallback_count  out  16  saturating fallback counter; busy  out  1  FSM not IDLE.

Function
REQ-016 Queue: QUEUE_DEPTH-entry FIFO of {id, data, is_safe}; push on in_valid && in_ready; in_ready = !full (combinational from registered count).
REQ-017 Push and pop in same cycle SHALL be legal when not full; count unchanged; pointers wrap modulo QUEUE_DEPTH.
REQ-018 FSM states: IDLE, PAR_WAIT, SER_OUT.
REQ-019 IDLE, queue non-empty, head safe, popcount(~core_busy) >= MIN_CORES: pop head into hold register, next cycle par_valid=1 with par_core_mask = lowest-index MIN_CORES idle cores, go PAR_WAIT.
REQ-020 IDLE, head unsafe: pop into hold, go SER_OUT with ser_is_fallback=0.
REQ-021 IDLE, head safe, insufficient idle cores: stay IDLE, increment stall counter; at STALL_LIMIT consecutive stall cycles pop into hold, go SER_OUT, ser_is_fallback=0; stall counter clears on any pop.
REQ-022 PAR_WAIT: commit_valid with commit_block_id == held id and commit_match=1 -> commit_ok pulse next cycle, go IDLE.
REQ-023 PAR_WAIT: matching id with commit_match=0 -> go SER_OUT, ser_is_fallback=1, fallback_count +1.
REQ-024 PAR_WAIT: commit with non-matching id SHALL be ignored.
REQ-025 PAR_WAIT: timer counts cycles from entry; on reaching TIMEOUT_CYCLES without matching commit -> SER_OUT, ser_is_fallback=1, fallback_count +1; matching commit in the timeout cycle wins.
REQ-026 SER_OUT: ser_valid=1, ser_block_id/data/ser_is_fallback stable until ser_valid && ser_ready; then IDLE, ser_valid low next cycle.
REQ-027 fallback_count SHALL saturate at 16'hFFFF.
REQ-028 Minimum latency: push into empty queue at cycle N -> par_valid or ser_valid asserted at cycle N+2.
REQ-029 par_block_id/data SHALL hold last issued values after par_valid drops; par_core_mask zero when par_valid low.
REQ-030 At most one block in flight; queue continues accepting while PAR_WAIT/SER_OUT.

Reset
REQ-031 rst high SHALL asynchronously force: FSM IDLE, queue empty, in_ready=1 on release, par_valid=0, par_core_mask=0, par_block_id/data=0, ser_valid=0, ser_is_fallback=0, ser_block_id/data=0, commit_ok=0, fallback_count=0, busy=0, all timers 0.
REQ-032 Reset mid-operation SHALL drop queued and in-flight blocks without any output pulse.

Verification
REQ-033 Push safe id 0x05, core_busy=4'b0000 -> par_valid at N+2, par_core_mask=4'b0011, par_block_id=0x05; commit (0x05, match=1) -> commit_ok pulse, busy=0.
REQ-034 Push safe id 0x07, core_busy=4'b1011 (one idle) for 16 cycles -> ser_valid, ser_block_id=0x07, ser_is_fallback=0.
REQ-035 Parallel id 0x09, commit (0x09, match=0) -> ser_valid, ser_is_fallback=1, fallback_count=1; ser_ready low 3 cycles -> outputs stable.
REQ-036 Parallel id 0x0A, only commit (0x0B) -> ignored; after 64 cycles ser_is_fallback=1, fallback_count increments.
REQ-037 Push 5 blocks back-to-back while PAR_WAIT -> in_ready low after 4 accepted; drain preserves order, ids wrap correctly.
REQ-038 Assert rst during SER_OUT -> ser_valid=0 immediately, queue empty, fallback_count=0.
